// File: rtl/fwd_pkg.sv
// Shared types and helpers for the operand-forwarding scoreboard.
package fwd_pkg;

   localparam int unsigned REG_ZERO = 0;

   typedef struct packed {
      logic valid;
      logic regwrite;
      logic is_load;
   } entry_ctl_t;

   // Select width wide enough to name "register file" plus every stage.
   function automatic int sel_w(input int num_stages);
      return (num_stages < 1) ? 1 : $clog2(num_stages + 1);
   endfunction

endpackage

// File: rtl/forward_scoreboard_if.sv
// ID-side request and EX-side forwarding response bundle of the scoreboard.
interface forward_scoreboard_if
   import fwd_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int REG_AW     = 5
);
   localparam int SEL_W = sel_w(NUM_STAGES);

   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_regwrite;
   logic                      id_is_load;
   logic                      flush;
   logic                      ex_valid;
   logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
   logic                      stall;
   logic [31:0]               stall_count;

   modport master (
      output id_valid, id_rs, id_rd, id_regwrite, id_is_load, flush,
      input  ex_valid, fwd_sel, stall, stall_count
   );

   modport slave (
      input  id_valid, id_rs, id_rd, id_regwrite, id_is_load, flush,
      output ex_valid, fwd_sel, stall, stall_count
   );

endinterface

// File: rtl/fwd_match.sv
// Priority match of one source register against a run of pipeline entries;
// the youngest (lowest-numbered) writing entry wins.
module fwd_match
   import fwd_pkg::*;
#(
   parameter int NUM_ENT    = 2,
   parameter int FIRST      = 1,
   parameter int REG_AW     = 5,
   parameter int SEL_W      = 2,
   parameter int LOAD_STAGE = 2
) (
   input  logic [NUM_ENT-1:0]        i_valid,
   input  logic [NUM_ENT-1:0]        i_regwrite,
   input  logic [NUM_ENT-1:0]        i_is_load,
   input  logic [NUM_ENT*REG_AW-1:0] i_rd,
   input  logic [REG_AW-1:0]         i_rs,
   output logic [SEL_W-1:0]          o_sel,
   output logic                      o_load_hit
);

   logic [NUM_ENT-1:0] w_hit;

   // Per-entry match: a real write to a nonzero register equal to the source.
   always_comb begin
      w_hit = '0;
      for (int e = 0; e < NUM_ENT; e++) begin
         w_hit[e] = i_valid[e] & i_regwrite[e]
                  & (i_rd[e*REG_AW +: REG_AW] != REG_AW'(REG_ZERO))
                  & (i_rd[e*REG_AW +: REG_AW] == i_rs);
      end
   end

   // Walk oldest to youngest so the youngest hit overwrites older ones.
   always_comb begin
      o_sel      = '0;
      o_load_hit = 1'b0;
      for (int e = NUM_ENT - 1; e >= 0; e--) begin
         o_sel      = w_hit[e] ? SEL_W'(e + FIRST) : o_sel;
         o_load_hit = w_hit[e] ? (i_is_load[e] & ((e + FIRST + 1) < LOAD_STAGE))
                               : o_load_hit;
      end
   end

endmodule

// File: rtl/forward_scoreboard.sv
// Tracks in-flight destinations after EX, produces per-source forwarding
// selects for the EX instruction and a load-use stall for the ID instruction.
module forward_scoreboard
   import fwd_pkg::*;
#(
   parameter int NUM_SRC    = 2,
   parameter int NUM_STAGES = 2,
   parameter int LOAD_STAGE = 2,
   parameter int REG_AW     = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   forward_scoreboard_if.slave  bus
);

   localparam int SEL_W = sel_w(NUM_STAGES);

   typedef struct packed {
      entry_ctl_t                ctl;
      logic [REG_AW-1:0]         rd;
      logic [NUM_SRC*REG_AW-1:0] rs;
   } entry_t;

   entry_t                         r_pipe [0:NUM_STAGES];
   logic [31:0]                    r_stall_count;

   entry_t                         w_id_ent;
   logic                           w_accept;
   logic                           w_stall;
   logic [NUM_STAGES:0]            w_valid;
   logic [NUM_STAGES:0]            w_regwrite;
   logic [NUM_STAGES:0]            w_is_load;
   logic [(NUM_STAGES+1)*REG_AW-1:0] w_rd;
   logic [NUM_SRC*SEL_W-1:0]       w_ex_sel;
   logic [NUM_SRC*SEL_W-1:0]       w_fwd_sel;
   logic [NUM_SRC*SEL_W-1:0]       w_id_sel_unused;
   logic [NUM_SRC-1:0]             w_ex_load_hit_unused;
   logic [NUM_SRC-1:0]             w_id_load_hit;

   // Flatten entry fields so the matchers can take contiguous stage ranges.
   always_comb begin
      w_valid    = '0;
      w_regwrite = '0;
      w_is_load  = '0;
      w_rd       = '0;
      for (int j = 0; j <= NUM_STAGES; j++) begin
         w_valid[j]                = r_pipe[j].ctl.valid;
         w_regwrite[j]             = r_pipe[j].ctl.regwrite;
         w_is_load[j]              = r_pipe[j].ctl.is_load;
         w_rd[j*REG_AW +: REG_AW]  = r_pipe[j].rd;
      end
   end

   // EX sources look at stages 1..NUM_STAGES; ID sources look at 0..NUM_STAGES-1,
   // which is where each producer will sit one edge later, relative to EX.
   for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
      fwd_match #(
         .NUM_ENT    (NUM_STAGES),
         .FIRST      (1),
         .REG_AW     (REG_AW),
         .SEL_W      (SEL_W),
         .LOAD_STAGE (LOAD_STAGE)
      ) u_ex_match (
         .i_valid    (w_valid[NUM_STAGES:1]),
         .i_regwrite (w_regwrite[NUM_STAGES:1]),
         .i_is_load  (w_is_load[NUM_STAGES:1]),
         .i_rd       (w_rd[(NUM_STAGES+1)*REG_AW-1:REG_AW]),
         .i_rs       (r_pipe[0].rs[k*REG_AW +: REG_AW]),
         .o_sel      (w_ex_sel[k*SEL_W +: SEL_W]),
         .o_load_hit (w_ex_load_hit_unused[k])
      );

      fwd_match #(
         .NUM_ENT    (NUM_STAGES),
         .FIRST      (0),
         .REG_AW     (REG_AW),
         .SEL_W      (SEL_W),
         .LOAD_STAGE (LOAD_STAGE)
      ) u_id_match (
         .i_valid    (w_valid[NUM_STAGES-1:0]),
         .i_regwrite (w_regwrite[NUM_STAGES-1:0]),
         .i_is_load  (w_is_load[NUM_STAGES-1:0]),
         .i_rd       (w_rd[NUM_STAGES*REG_AW-1:0]),
         .i_rs       (bus.id_rs[k*REG_AW +: REG_AW]),
         .o_sel      (w_id_sel_unused[k*SEL_W +: SEL_W]),
         .o_load_hit (w_id_load_hit[k])
      );
   end

   // Build the candidate P[0] entry and the stall/accept decision.
   always_comb begin
      w_id_ent.ctl.valid    = bus.id_valid;
      w_id_ent.ctl.regwrite = bus.id_regwrite;
      w_id_ent.ctl.is_load  = bus.id_is_load;
      w_id_ent.rd           = bus.id_rd;
      w_id_ent.rs           = bus.id_rs;
      w_stall               = bus.id_valid & ~bus.flush & (|w_id_load_hit);
      w_accept              = bus.id_valid & ~bus.flush & ~w_stall;
   end

   // A bubble in EX must never forward, whatever stale fields it carries.
   always_comb begin
      w_fwd_sel = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_fwd_sel[k*SEL_W +: SEL_W] = r_pipe[0].ctl.valid ? w_ex_sel[k*SEL_W +: SEL_W]
                                                           : SEL_W'(0);
      end
   end

   // Advance the pipeline image; P[0] takes the ID instruction or a bubble.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int j = 0; j <= NUM_STAGES; j++) begin
            r_pipe[j] <= '0;
         end
      end else begin
         r_pipe[0] <= w_accept ? w_id_ent : '0;
         for (int j = 1; j <= NUM_STAGES; j++) begin
            r_pipe[j] <= r_pipe[j-1];
         end
      end
   end

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_count <= 32'd0;
      end else if (w_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
         r_stall_count <= r_stall_count + 32'd1;
      end else begin
         r_stall_count <= r_stall_count;
      end
   end

   assign bus.ex_valid    = r_pipe[0].ctl.valid;
   assign bus.fwd_sel     = w_fwd_sel;
   assign bus.stall       = w_stall;
   assign bus.stall_count = r_stall_count;

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard with an issue-history reference model.
module tb_forward_scoreboard;

   localparam int NS = 2;
   localparam int LS = 2;

   logic clk;
   logic rst;

   forward_scoreboard_if #(.NUM_SRC(2), .NUM_STAGES(NS), .REG_AW(5)) bus ();

   forward_scoreboard #(
      .NUM_SRC    (2),
      .NUM_STAGES (NS),
      .LOAD_STAGE (LS),
      .REG_AW     (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass;
   int n_total;

   // Issue history: record e describes the instruction accepted at edge e.
   int n;
   bit m_acc [0:1023];
   bit m_rw  [0:1023];
   bit m_ld  [0:1023];
   int m_rd  [0:1023];
   int m_rs0 [0:1023];
   int m_rs1 [0:1023];
   int m_cnt;

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic bit rec_writes(input int e, input int r);
      if (e < 0) return 1'b0;
      return m_acc[e] && m_rw[e] && (m_rd[e] != 0) && (m_rd[e] == r);
   endfunction

   // Youngest producer of r among the instructions issued 1..NS edges before EX.
   function automatic int exp_sel(input int r);
      int res;
      res = 0;
      if (m_acc[n]) begin
         for (int j = NS; j >= 1; j--) begin
            if (rec_writes(n - j, r)) res = j;
         end
      end
      return res;
   endfunction

   function automatic bit exp_stall();
      bit st;
      int r;
      int youngest;
      st = 1'b0;
      if (bus.id_valid && !bus.flush && !rst) begin
         for (int k = 0; k < 2; k++) begin
            r = (k == 0) ? int'(bus.id_rs[4:0]) : int'(bus.id_rs[9:5]);
            youngest = -1;
            for (int j = NS - 1; j >= 0; j--) begin
               if (rec_writes(n - j, r)) youngest = j;
            end
            if (youngest >= 0 && m_ld[n - youngest] && (youngest + 1 < LS)) st = 1'b1;
         end
      end
      return st;
   endfunction

   task automatic step(input string tag, input bit v, input int rd, input int rs0,
                       input int rs1, input bit rw, input bit ld, input bit fl,
                       input bit pin, input int p_exv, input int p_s0, input int p_s1,
                       input int p_st, input int p_cnt);
      bit e_st;
      bus.id_valid    = v;
      bus.id_rd       = 5'(rd);
      bus.id_rs       = {5'(rs1), 5'(rs0)};
      bus.id_regwrite = rw;
      bus.id_is_load  = ld;
      bus.flush       = fl;
      @(negedge clk);
      e_st = exp_stall();
      check({tag, "/ex_valid"}, int'(bus.ex_valid), int'(m_acc[n]));
      check({tag, "/sel0"}, int'(bus.fwd_sel[1:0]), exp_sel(m_rs0[n]));
      check({tag, "/sel1"}, int'(bus.fwd_sel[3:2]), exp_sel(m_rs1[n]));
      check({tag, "/stall"}, int'(bus.stall), int'(e_st));
      check({tag, "/count"}, int'(bus.stall_count), m_cnt);
      if (pin) begin
         check({tag, "/pin_ex_valid"}, int'(bus.ex_valid), p_exv);
         check({tag, "/pin_sel0"}, int'(bus.fwd_sel[1:0]), p_s0);
         check({tag, "/pin_sel1"}, int'(bus.fwd_sel[3:2]), p_s1);
         check({tag, "/pin_stall"}, int'(bus.stall), p_st);
         check({tag, "/pin_count"}, int'(bus.stall_count), p_cnt);
      end
      @(posedge clk);
      n++;
      m_acc[n] = v && !fl && !e_st && !rst;
      m_rw[n]  = rw;
      m_ld[n]  = ld;
      m_rd[n]  = rd;
      m_rs0[n] = rs0;
      m_rs1[n] = rs1;
      if (e_st && !rst) m_cnt++;
      #1;
   endtask

   task automatic drain();
      step("drain", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("drain", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      n_pass = 0;
      n_total = 0;
      n = 0;
      m_cnt = 0;
      for (int i = 0; i < 1024; i++) begin
         m_acc[i] = 1'b0; m_rw[i] = 1'b0; m_ld[i] = 1'b0;
         m_rd[i] = 0; m_rs0[i] = 0; m_rs1[i] = 0;
      end
      rst = 1'b1;
      bus.id_valid = 1'b1;
      bus.id_rs = {5'd3, 5'd3};
      bus.id_rd = 5'd3;
      bus.id_regwrite = 1'b1;
      bus.id_is_load = 1'b1;
      bus.flush = 1'b0;
      #3;
      check("reset/ex_valid", int'(bus.ex_valid), 0);
      check("reset/fwd_sel", int'(bus.fwd_sel), 0);
      check("reset/stall", int'(bus.stall), 0);
      check("reset/count", int'(bus.stall_count), 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_edge/ex_valid", int'(bus.ex_valid), 0);
      rst = 1'b0;

      // add x5 ; add x6,x5,x1
      step("t1_prod", 1'b1, 5, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t1_use",  1'b1, 6, 5, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t1_chk",  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 0);
      drain();

      // add x5 ; nop ; sub x8,x2,x5
      step("t2_prod", 1'b1, 5, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t2_nop",  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t2_use",  1'b1, 8, 2, 5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t2_chk",  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 2, 0, 0);
      drain();

      // add x7 ; add x7 ; use x7 -> youngest; then x0 producer and use
      step("t3_p_old", 1'b1, 7, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t3_p_new", 1'b1, 7, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t3_use",   1'b1, 9, 7, 7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t3_chk",   1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1, 0, 0);
      step("t3_x0p",   1'b1, 0, 1, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t3_x0use", 1'b1, 9, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t3_x0chk", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);
      drain();

      // lw x3 ; add x4,x3,x3 -> one stall, bubble, then forward from stage 2
      step("t4_lw",    1'b1, 3, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t4_stall", 1'b1, 4, 3, 3, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 1, 0);
      step("t4_retry", 1'b1, 4, 3, 3, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1);
      step("t4_chk",   1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 2, 0, 1);
      drain();

      // load-use with flush in the same cycle
      step("t5_lw",    1'b1, 3, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t5_flush", 1'b1, 4, 3, 3, 1'b1, 1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 1);
      step("t5_chk",   1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 1);
      drain();

      // lw x3 ; add x3 ; use x3 -> younger ALU write masks the load
      step("t6_lw",   1'b1, 3, 1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t6_alu",  1'b1, 3, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t6_use",  1'b1, 4, 3, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 1);
      step("t6_chk",  1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 1);
      drain();

      // two producers in flight, then asynchronous reset
      step("t7_p10", 1'b1, 10, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      step("t7_p11", 1'b1, 11, 1, 2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
      bus.id_valid = 1'b1;
      bus.id_rs = {5'd11, 5'd10};
      bus.flush = 1'b0;
      #1;
      check("t7_pre/ex_valid", int'(bus.ex_valid), 1);
      rst = 1'b1;
      #1;
      check("rst_mid/ex_valid", int'(bus.ex_valid), 0);
      check("rst_mid/fwd_sel", int'(bus.fwd_sel), 0);
      check("rst_mid/stall", int'(bus.stall), 0);
      check("rst_mid/count", int'(bus.stall_count), 0);
      for (int i = 0; i < 1024; i++) m_acc[i] = 1'b0;
      m_cnt = 0;
      step("t7_inrst", 1'b1, 12, 10, 11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step("t7_cons",  1'b1, 12, 10, 11, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 0, 0, 0);
      step("t7_chk",   1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0, 0, 0, 0);

      // mixed traffic over a small register set, checked against the model
      for (int i = 0; i < 48; i++) begin
         step("mix", 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), 1'b0, 0, 0, 0, 0, 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/forward_scoreboard.md
FORWARD_SCOREBOARD -- requirements
Module: forward_scoreboard

Interface
REQ-001 Parameter NUM_SRC, default 2: number of source operands per instruction.
REQ-002 Parameter NUM_STAGES, default 2: number of forwardable stages after EX (stage 1 = EX/MEM, stage NUM_STAGES = last write-back stage).
REQ-003 Parameter LOAD_STAGE, default 2: first stage (1..NUM_STAGES) at which load data is forwardable.
REQ-004 Parameter REG_AW, default 5: register address width.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port rst, input, 1: asynchronous, active-high reset.
REQ-007 Port id_valid, input, 1: the ID-stage instruction is valid.
REQ-008 Port id_rs, input, NUM_SRC*REG_AW: ID source register addresses, with source k at bits [k*REG_AW +: REG_AW].
REQ-009 Port id_rd / id_regwrite / id_is_load, input, REG_AW / 1 / 1: ID destination, write enable, and load flag.
REQ-010 Port flush, input, 1: the ID instruction is discarded this cycle.
REQ-011 Port ex_valid, output, 1: the EX-stage entry (P[0]) is valid.
REQ-012 Port fwd_sel, output, NUM_SRC*SEL_W, where SEL_W = $clog2(NUM_STAGES+1): per EX source, 0 selects the register file and j selects stage j.
REQ-013 Port stall, output, 1: hold PC and IF/ID, and insert a bubble into EX.
REQ-014 Port stall_count, output, 32: saturating count of stall cycles.

Function
REQ-015 The block SHALL hold entries P[0..NUM_STAGES]; each entry holds {valid, rd, regwrite, is_load, rs[NUM_SRC]}.
REQ-016 Each rising edge SHALL shift P[j] into P[j+1] for j = 0..NUM_STAGES-1, and P[NUM_STAGES] SHALL be discarded.
REQ-017 P[0] SHALL load the ID fields when id_valid=1, stall=0 and flush=0; otherwise P[0] SHALL load a bubble (valid=0).
REQ-018 A stage j SHALL match EX source k when P[j].valid, P[j].regwrite, P[j].rd != 0, and P[j].rd == P[0].rs[k].
REQ-019 fwd_sel[k] SHALL be the lowest matching j in 1..NUM_STAGES (the youngest producer wins), or 0 when there is no match or P[0].valid=0; it is combinational from registered state.
REQ-020 stall SHALL be asserted combinationally when id_valid=1, flush=0, and some ID source k (rs != 0) matches a load entry P[j] with j+1 < LOAD_STAGE.
REQ-021 With the defaults, REQ-020 SHALL reduce to a classic load-use stall of exactly 1 cycle against P[0].
REQ-022 A younger non-load match in a stage earlier than the load SHALL mask the load (no stall).
REQ-023 flush=1 SHALL force stall=0 and a P[0] bubble in the same cycle; older entries SHALL still advance.
REQ-024 stall_count SHALL increment by 1 each cycle stall=1, saturating at 32'hFFFF_FFFF.
REQ-025 Latency: the ID instruction SHALL appear in P[0] (ex_valid=1) one cycle after acceptance.

Reset
REQ-026 While rst=1, all entry valid bits SHALL be 0 and stall_count SHALL be 0, asynchronously.
REQ-027 During and after reset, fwd_sel SHALL be 0, stall 0, and ex_valid 0.
REQ-028 Reset asserted mid-stream SHALL drop all in-flight entries; no forwarding from pre-reset entries SHALL occur.
REQ-029 The first edge after reset deassertion SHALL accept ID normally.

Structure
REQ-030 Package fwd_pkg SHALL hold the entry struct typedef, the SEL_W helper function, and the REG_ZERO constant.
REQ-031 Sub-module fwd_match SHALL implement one source's priority match across the stages, returning the select index and a load-hit flag; it is instantiated NUM_SRC times for EX and NUM_SRC times for ID.
REQ-032 Flop count SHALL scale with NUM_STAGES and NUM_SRC only; there SHALL be no hard-coded stage count.

Verification (defaults)
REQ-033 Issue add x5, then add x6,x5,x1 -> in the consumer's EX cycle, fwd_sel[0]=1 and fwd_sel[1]=0.
REQ-034 Issue add x5, nop, then sub using x5 as rs2 -> fwd_sel[1]=2 and fwd_sel[0]=0.
REQ-035 Issue add x7, add x7, then use x7 -> fwd_sel=1 (youngest producer); write to x0 with regwrite=1 followed by a use of x0 -> fwd_sel=0.
REQ-036 Issue lw x3, then add x4,x3,x3 -> stall=1 for exactly 1 cycle and stall_count=1; the next cycle P[0] is a bubble; the following cycle fwd_sel[0]=fwd_sel[1]=2.
REQ-037 Load-use hazard with flush=1 in the same cycle -> stall=0, ex_valid=0 next cycle, stall_count unchanged.
REQ-038 Assert rst mid-stream with two valid producers in flight -> outputs zero immediately; after release, a consumer of those registers gets fwd_sel=0.
